// File: rtl/sync_fifo_ext.sv
// Parametrised single-clock FIFO with threshold flags, fill level, sticky error flags
// and an elaboration-time choice between registered-read and first-word-fall-through output.
module sync_fifo_ext #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       w_en,
  input  logic                       r_en,
  input  logic                       clear,
  input  logic [DATA_W-1:0]          data_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_ok;
  logic              rd_ok;

  // Handshake: w_en/r_en are requests, accepted only when the pre-edge full/empty
  // flag allows it; there is no pass-through between a read and a write in one cycle.
  assign wr_ok = w_en && !full;
  assign rd_ok = r_en && !empty;

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign count        = cnt;

  // Storage is not reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_ok && !rd_ok)      cnt <= cnt + CNT_W'(1);
      else if (rd_ok && !wr_ok) cnt <= cnt - CNT_W'(1);
      // A fresh error event takes priority over a simultaneous clear.
      if (w_en && full)  overflow <= 1'b1;
      else if (clear)    overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (clear)    underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (!rst_n)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: one registered-read and one FWFT instance share stimulus
// and are both checked against a queue-based reference model.
module tb_sync_fifo_ext;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w_en;
  logic       r_en;
  logic       clear;
  logic [7:0] data_in;

  logic [7:0] dout_r, dout_f;
  logic       full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic       full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [3:0] cnt_r, cnt_f;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_unf;
  logic [7:0] m_dout;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .clear(clear), .data_in(data_in),
    .data_out(dout_r), .full(full_r), .empty(empty_r), .almost_full(af_r),
    .almost_empty(ae_r), .count(cnt_r), .overflow(ovf_r), .underflow(unf_r)
  );

  sync_fifo_ext #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .r_en(r_en), .clear(clear), .data_in(data_in),
    .data_out(dout_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(cnt_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("count_r", 32'(cnt_r), 32'(n));
    check("count_f", 32'(cnt_f), 32'(n));
    check("full_r", 32'(full_r), 32'(n == 8));
    check("full_f", 32'(full_f), 32'(n == 8));
    check("empty_r", 32'(empty_r), 32'(n == 0));
    check("empty_f", 32'(empty_f), 32'(n == 0));
    check("af_r", 32'(af_r), 32'(n >= 6));
    check("af_f", 32'(af_f), 32'(n >= 6));
    check("ae_r", 32'(ae_r), 32'(n <= 2));
    check("ae_f", 32'(ae_f), 32'(n <= 2));
    check("ovf_r", 32'(ovf_r), 32'(m_ovf));
    check("ovf_f", 32'(ovf_f), 32'(m_ovf));
    check("unf_r", 32'(unf_r), 32'(m_unf));
    check("unf_f", 32'(unf_f), 32'(m_unf));
    check("dout_r", 32'(dout_r), 32'(m_dout));
    if (n > 0) check("dout_f", 32'(dout_f), 32'(exp_q[0]));
  endtask

  // One clock cycle: drive inputs, advance the model from pre-edge state, check after edge.
  task automatic cyc(input logic rst, input logic w, input logic r, input logic c,
                     input logic [7:0] d);
    bit was_full, was_empty;
    rst_n = rst; w_en = w; r_en = r; clear = c; data_in = d;
    if (!rst) begin
      exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;
    end else begin
      was_full  = (exp_q.size() == 8);
      was_empty = (exp_q.size() == 0);
      if (r && !was_empty) m_dout = exp_q.pop_front();
      if (w && !was_full)  exp_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [7:0] d);  cyc(1'b1, 1'b1, 1'b0, 1'b0, d); endtask
  task automatic rd();                     cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'($urandom)); endtask
  task automatic idle();                   cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom)); endtask

  initial begin
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; clear = 1'b0; data_in = 8'h00;
    exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = 8'h00;

    // reset held with both requests active
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
    idle();

    // fill/drain twice to cross the pointer wrap
    for (int i = 1; i <= 8; i++) wr(8'(i));
    for (int i = 0; i < 8; i++) rd();
    for (int i = 1; i <= 8; i++) wr(8'(8'h10 + i));
    for (int i = 0; i < 8; i++) rd();

    // overflow, underflow, clear, and set-beats-clear
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    wr(8'hAA);
    for (int i = 0; i < 8; i++) rd();
    rd();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) wr(8'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hAA);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

    // simultaneous access: full, steady count 3, empty
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hBB);
    for (int i = 0; i < 4; i++) rd();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 3; i++) rd();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hC3);
    rd();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);

    // FWFT latency: word visible with no read, then popped
    wr(8'h5C);
    idle();
    rd();

    // mid-operation reset with count 5
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    wr(8'h33);
    rd();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) == 0), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
